shift_seq_ctrl: RTL and testbench

Sequential controller that runs the single-position combinational shifter `shift_8bit` over several clock cycles. It captures an 8-bit operand, a direction and a shift amount on a start handshake. It then steps the operand through `shift_8bit` once per cycle until the requested amount is reached, and presents the result with a one-cycle `done` pulse. It sits between a requesting controller or testbench and the shifter datapath, turning a 1-bit shifter into a variable-amount shift unit.

---
 rtl/shift_ctrl_pkg.sv | 22 ++
 rtl/shift_seq_ctrl_shift_8bit.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 118 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_ctrl_pkg
//
// Shared definitions for the multi-cycle shift controller:
//   - state_e   : controller FSM encoding (binary, 2 bits)
//   - DIR_*     : shift-direction codes carried on lr / dir register
//   - DATA_W    : operand width of the shifter datapath
// ---------------------------------------------------------------------------
package shift_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_ctrl_pkg

// File: rtl/shift_seq_ctrl_shift_8bit.sv
// ---------------------------------------------------------------------------
// shift_8bit
//
// Purely combinational single-position logical shifter with zero fill.
//
// Ports:
//   a  [7:0] in  : operand
//   lr       in  : direction, DIR_LEFT (0) or DIR_RIGHT (1)
//   y  [7:0] out : a shifted by exactly one position
// ---------------------------------------------------------------------------
module shift_8bit
    import shift_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic              lr,
    output logic [DATA_W-1:0] y
);

    // Each output bit picks its left or right neighbour; the edge bits have
    // no neighbour on one side and receive the zero fill instead.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        logic from_lower;
        logic from_upper;

        if (gi == 0) begin : g_lsb
            assign from_lower = 1'b0;
        end else begin : g_lower
            assign from_lower = a[gi-1];
        end

        if (gi == DATA_W - 1) begin : g_msb
            assign from_upper = 1'b0;
        end else begin : g_upper
            assign from_upper = a[gi+1];
        end

        assign y[gi] = (lr == DIR_RIGHT) ? from_upper : from_lower;
    end

endmodule : shift_8bit

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Variable-amount shift unit built from a single-position shifter that is
// stepped once per clock. An operand, direction and amount are captured on a
// start handshake; the result is presented on y with a one-cycle done pulse.
//
// Parameters:
//   AMT_W          : width of the shift amount (max amount 2^AMT_W-1)
//
// Ports:
//   clk            in  : clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   start          in  : request, sampled only while busy is low
//   a      [7:0]   in  : operand, captured on accept
//   lr             in  : direction (0 left, 1 right), captured on accept
//   amt [AMT_W-1:0] in : number of one-bit steps, captured on accept
//   y      [7:0]   out : result register (intermediate values while busy)
//   busy           out : FSM not in IDLE
//   done           out : one-cycle pulse, y final
// ---------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic              lr,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] y,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              dir_q,   dir_d;
    logic [AMT_W-1:0]  cnt_q,   cnt_d;

    logic [DATA_W-1:0] step_y;

    // One-position step of the held operand; consumed only in SHIFT.
    shift_8bit u_shift (
        .a  (data_q),
        .lr (dir_q),
        .y  (step_y)
    );

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= DIR_LEFT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = a;
                    dir_d   = lr;
                    cnt_d   = amt;
                    // A zero amount skips SHIFT entirely so y == a at done.
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end

            SHIFT: begin
                data_d = step_y;
                cnt_d  = cnt_q - AMT_W'(1);
                // Leave on the step that consumes the last count, so done
                // appears in the cycle after edge amt.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // start is deliberately not sampled here: no queuing.
                state_d = IDLE;
            end

            default: begin
                // Unreachable encoding 2'd3: recover to IDLE.
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: y is the data register; flags decode the state register only.
    // -----------------------------------------------------------------------
    assign y    = data_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Directed testbench for shift_seq_ctrl. Inputs are changed 1 time unit after
// a rising edge and outputs are sampled at the same point, away from the edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_seq_ctrl;

    localparam int AMT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       a;
    logic             lr;
    logic [AMT_W-1:0] amt;
    logic [7:0]       y;
    logic             busy;
    logic             done;

    int checks;
    int errors;

    shift_seq_ctrl #(.AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .lr    (lr),
        .amt   (amt),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let one edge accept it; returns just after edge 0.
    task automatic accept(input logic [7:0] av, input logic lv, input logic [AMT_W-1:0] mv);
        a     = av;
        lr    = lv;
        amt   = mv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        lr    = 1'b0;
        amt   = '0;
        step();
        step();
        checks++;
        if ({y, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got y=%h busy=%b done=%b, expected y=00 busy=0 done=0", y, busy, done);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({y, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_reset: got y=%h busy=%b done=%b, expected y=00 busy=0 done=0", y, busy, done);
        end
        $display("test_reset: y=%h busy=%b done=%b", y, busy, done);
    endtask

    task automatic test_left();
        accept(8'b10010110, 1'b0, 3'd1);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL left_cycle1: got busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        step();
        checks++;
        if ({y, busy, done} !== {8'b00101100, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL left_done: got y=%b busy=%b done=%b, expected y=00101100 busy=1 done=1", y, busy, done);
        end
        step();
        checks++;
        if ({y, busy, done} !== {8'b00101100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL left_idle: got y=%b busy=%b done=%b, expected y=00101100 busy=0 done=0", y, busy, done);
        end
        $display("test_left: a=10010110 amt=1 y=%b", y);
    endtask

    task automatic test_right();
        accept(8'b10010110, 1'b1, 3'd3);
        for (int e = 0; e < 3; e++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL right_shifting_e%0d: got busy=%b done=%b, expected busy=1 done=0", e, busy, done);
            end
            step();
        end
        checks++;
        if ({y, busy, done} !== {8'b00010010, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL right_done: got y=%b busy=%b done=%b, expected y=00010010 busy=1 done=1", y, busy, done);
        end
        step();
        checks++;
        if ({y, busy, done} !== {8'b00010010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL right_pulse_end: got y=%b busy=%b done=%b, expected y=00010010 busy=0 done=0", y, busy, done);
        end
        $display("test_right: a=10010110 amt=3 y=%b", y);
    endtask

    task automatic test_zero();
        accept(8'b10010110, 1'b0, 3'd0);
        checks++;
        if ({y, busy, done} !== {8'b10010110, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_done: got y=%b busy=%b done=%b, expected y=10010110 busy=1 done=1", y, busy, done);
        end
        step();
        checks++;
        if ({y, busy, done} !== {8'b10010110, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zero_idle: got y=%b busy=%b done=%b, expected y=10010110 busy=0 done=0", y, busy, done);
        end
        $display("test_zero: a=10010110 amt=0 y=%b", y);
    endtask

    task automatic test_flush();
        logic [7:0] a_tab [2];
        logic [7:0] y_tab [2];
        a_tab[0] = 8'hFF;       y_tab[0] = 8'b10000000;
        a_tab[1] = 8'b10010110; y_tab[1] = 8'h00;
        for (int t = 0; t < 2; t++) begin
            accept(a_tab[t], 1'b0, 3'd7);
            repeat (7) step();
            checks++;
            if ({y, done} !== {y_tab[t], 1'b1}) begin
                errors++;
                $display("FAIL flush_%0d: got y=%b done=%b, expected y=%b done=1", t, y, done, y_tab[t]);
            end
            step();
            $display("test_flush: a=%h amt=7 y=%b", a_tab[t], y);
        end
    endtask

    // Also exercises back-to-back: the follow-up request lands on edge amt+2.
    task automatic test_busy_protect();
        accept(8'hB5, 1'b1, 3'd5);
        for (int e = 0; e < 5; e++) begin
            // Intruding request while SHIFT is in progress.
            start = (e == 1);
            a     = 8'h0F;
            lr    = 1'b0;
            amt   = 3'd1;
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL busy_shifting_e%0d: got busy=%b done=%b, expected busy=1 done=0", e, busy, done);
            end
            step();
        end
        start = 1'b1;   // intruding request in the DONE cycle
        checks++;
        if ({y, busy, done} !== {8'h05, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL busy_result: got y=%h busy=%b done=%b, expected y=05 busy=1 done=1", y, busy, done);
        end
        step();
        start = 1'b0;
        checks++;
        if ({y, busy, done} !== {8'h05, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL busy_ignored_in_done: got y=%h busy=%b done=%b, expected y=05 busy=0 done=0", y, busy, done);
        end
        $display("test_busy_protect: a=B5 amt=5 right y=%h", y);
        accept(8'h0F, 1'b0, 3'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, expected busy=1", busy);
        end
        step();
        checks++;
        if ({y, done} !== {8'h1E, 1'b1}) begin
            errors++;
            $display("FAIL b2b_result: got y=%h done=%b, expected y=1E done=1", y, done);
        end
        step();
        $display("test_back_to_back: a=0F amt=1 left y=%h", y);
    endtask

    task automatic test_reset_mid();
        accept(8'b10010110, 1'b0, 3'd6);
        repeat (3) step();
        checks++;
        if ({y, busy} !== {8'hB0, 1'b1}) begin
            errors++;
            $display("FAIL mid_progress: got y=%h busy=%b, expected y=B0 busy=1", y, busy);
        end
        #2 rst_n = 1'b0;   // mid-cycle, no clock edge involved
        #1;
        checks++;
        if ({y, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_async_reset: got y=%h busy=%b done=%b, expected y=00 busy=0 done=0", y, busy, done);
        end
        step();
        rst_n = 1'b1;
        step();
        accept(8'b10010110, 1'b1, 3'd2);
        repeat (2) step();
        checks++;
        if ({y, busy, done} !== {8'h25, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_op: got y=%h busy=%b done=%b, expected y=25 busy=1 done=1", y, busy, done);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
        $display("test_reset_mid: post-reset a=96 amt=2 right y=%h", y);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_left();
        test_right();
        test_zero();
        test_flush();
        test_busy_protect();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_seq_ctrl
